// File: rtl/spi_ram_slave_pkg.sv
// Shared definitions for the SPI-to-RAM slave: FSM states, command layout
// and default widths.
package spi_ram_slave_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // Bit of the command byte that selects read (1) or write (0).
  localparam int RW_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_ram_slave_if.sv
// SPI pins plus RAM-side bus of the SPI RAM slave, with slave/master views.
interface spi_ram_slave_if
  import spi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              enable;
  logic              rw;
  logic [ADDR_W-1:0] adrs;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              frame_err;

  modport slave (
    input  sclk, cs_n, mosi, dataout,
    output miso, enable, rw, adrs, datain, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, dataout,
    input  miso, enable, rw, adrs, datain, frame_err
  );

endinterface

// File: rtl/spi_ram_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detection
// on the synchronized copy.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one extra stage holding the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_slave.sv
// SPI mode-0 slave giving a master burst read/write access to an external
// RAM. Command byte: bit RW_BIT = direction, low ADDR_W bits = start address.
module spi_ram_slave
  import spi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic            clk,
  input logic            rst_n,
  spi_ram_slave_if.slave bus
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              enable_q, enable_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic              ferr_q, ferr_d;
  logic [1:0]        warm_q, warm_d;
  logic              arm_q, arm_d;
  logic [DATA_W-1:0] rx_next;
  logic              leave;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.sclk),
    .q_o    (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.cs_n),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi only needs to be level-aligned with the synchronized sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mosi_meta_q <= bus.mosi;
      mosi_q      <= mosi_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      enable_q  <= 1'b0;
      rw_q      <= 1'b1;
      adrs_q    <= '0;
      datain_q  <= '0;
      ferr_q    <= 1'b0;
      warm_q    <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      enable_q  <= enable_d;
      rw_q      <= rw_d;
      adrs_q    <= adrs_d;
      datain_q  <= datain_d;
      ferr_q    <= ferr_d;
      warm_q    <= warm_d;
      arm_q     <= arm_d;
    end
  end

  // Frame sequencing: command decode, byte assembly, RAM strobes, miso shifting.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    enable_d  = 1'b0;
    rw_d      = rw_q;
    adrs_d    = adrs_q;
    datain_d  = datain_q;
    ferr_d    = 1'b0;
    // After reset the cs_n synchronizer holds its reset value for two clocks;
    // only a real high level seen afterwards arms frame detection, so a frame
    // interrupted by reset is never resumed mid-stream.
    warm_d    = {warm_q[0], 1'b1};
    arm_d     = arm_q | (warm_q[1] & cs_lvl);
    rx_next   = {rx_q[DATA_W-2:0], mosi_q};
    leave     = 1'b0;

    // The read strobe cycle is when dataout reflects the new adrs.
    if (enable_q && rw_q) begin
      tx_d = bus.dataout;
    end

    unique case (state_q)
      IDLE: begin
        // Mode 0 keeps sclk low while cs_n is asserted.
        if (arm_q && cs_fall && !sclk_lvl) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = '0;
        end
      end
      CMD: begin
        if (cs_lvl) begin
          leave = 1'b1;
        end else if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            state_d   = DATA;
            rd_d      = rx_next[RW_BIT];
            addr_d    = rx_next[ADDR_W-1:0];
            if (rx_next[RW_BIT]) begin
              enable_d = 1'b1;
              rw_d     = 1'b1;
              adrs_d   = rx_next[ADDR_W-1:0];
            end
          end
        end
      end
      DATA: begin
        if (cs_lvl) begin
          leave = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              rx_d      = '0;
              addr_d    = addr_q + ADDR_W'(1);
              enable_d  = 1'b1;
              rw_d      = rd_q;
              if (rd_q) begin
                // Prefetch the byte the master will clock out next.
                adrs_d = addr_q + ADDR_W'(1);
              end else begin
                adrs_d   = addr_q;
                datain_d = rx_next;
              end
            end
          end
          // The falling edge right after a byte boundary must keep the freshly
          // loaded MSB on miso, so only mid-byte falls shift.
          if (sclk_fall && rd_q && (bit_cnt_q != '0)) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (leave) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      ferr_d    = cs_rise && (bit_cnt_q != '0);
    end
  end

  assign bus.miso      = (state_q == DATA && rd_q) ? tx_q[DATA_W-1] : 1'b0;
  assign bus.enable    = enable_q;
  assign bus.rw        = rw_q;
  assign bus.adrs      = adrs_q;
  assign bus.datain    = datain_q;
  assign bus.frame_err = ferr_q;

endmodule
